// File: rtl/secure_entry_ctrl.sv
// Credential-gated data-entry controller with a built-in prescaler tick and timed lockout.
// Optional macro SUBMIT_DEBOUNCE_EN inserts a synchroniser and debouncer on i_submit.
module secure_entry_ctrl #(
  parameter int unsigned       DATA_W      = 4,
  parameter int unsigned       CRED_W      = 4,
  parameter logic [CRED_W-1:0] CRED_KEY    = 4'hA,
  parameter int unsigned       MAX_TRIES   = 3,
  parameter int unsigned       TICK_DIV    = 50000000,
  parameter int unsigned       GRANT_TICKS = 2,
  parameter int unsigned       LOCK_TICKS  = 5,
  parameter int unsigned       DEB_CYC     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CRED_W-1:0] i_cred,
  input  logic              i_submit,
  output logic [DATA_W-1:0] o_acc,
  output logic              o_carry,
  output logic [3:0]        o_entries,
  output logic [3:0]        o_tries,
  output logic              o_led,
  output logic              o_err,
  output logic              o_lock,
  output logic              o_tick
);

  localparam int unsigned TickW    = $clog2(TICK_DIV);
  localparam int unsigned MaxDwell = (GRANT_TICKS > LOCK_TICKS) ? GRANT_TICKS : LOCK_TICKS;
  localparam int unsigned CntW     = (MaxDwell > 1) ? $clog2(MaxDwell) : 1;

  localparam logic [TickW-1:0] TickLast  = TickW'(TICK_DIV - 1);
  localparam logic [CntW-1:0]  GrantLast = CntW'(GRANT_TICKS - 1);
  localparam logic [CntW-1:0]  LockLast  = CntW'(LOCK_TICKS - 1);
  localparam logic [3:0]       TriesMax  = 4'(MAX_TRIES);

  typedef enum logic [2:0] {StIdle, StCheck, StGrant, StDeny, StLocked} state_e;

  state_e              state_q, state_d;
  logic [TickW-1:0]    tick_cnt_q, tick_cnt_d;
  logic                tick_q, tick_d;
  logic [CntW-1:0]     st_cnt_q, st_cnt_d;
  logic [CntW-1:0]     dwell_last;
  logic [DATA_W-1:0]   acc_q, acc_d, data_cap_q, data_cap_d;
  logic [CRED_W-1:0]   cred_cap_q, cred_cap_d;
  logic                carry_q, carry_d;
  logic [3:0]          entries_q, entries_d, tries_q, tries_d;
  logic                led_q, led_d, err_q, err_d, lock_q, lock_d;
  logic [DATA_W:0]     sum;
  logic                submit_lvl, submit_q, req;

`ifdef SUBMIT_DEBOUNCE_EN
  localparam int unsigned DebW = $clog2(DEB_CYC + 1);

  logic            sync1_q, sync2_q, deb_q, deb_d;
  logic [DebW-1:0] deb_cnt_q, deb_cnt_d;

  // Filtered level flips only after DEB_CYC consecutive cycles of disagreement.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (deb_cnt_q == DebW'(DEB_CYC - 1)) begin
        deb_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DebW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_q     <= 1'b0;
      deb_cnt_q <= '0;
    end else begin
      sync1_q   <= i_submit;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  assign submit_lvl = deb_q;
`else
  logic unused_deb;
  assign unused_deb = (DEB_CYC == 0);
  assign submit_lvl = i_submit;
`endif

  assign req = submit_lvl & ~submit_q;

  always_comb begin
    tick_cnt_d = (tick_cnt_q == TickLast) ? '0 : tick_cnt_q + TickW'(1);
    tick_d     = (tick_cnt_d == TickLast);
  end

  always_comb begin
    unique case (state_q)
      StGrant:  dwell_last = GrantLast;
      StLocked: dwell_last = LockLast;
      default:  dwell_last = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    st_cnt_d   = st_cnt_q;
    acc_d      = acc_q;
    carry_d    = carry_q;
    entries_d  = entries_q;
    tries_d    = tries_q;
    data_cap_d = data_cap_q;
    cred_cap_d = cred_cap_q;
    sum        = {1'b0, acc_q} + {1'b0, data_cap_q};

    unique case (state_q)
      StIdle: begin
        if (req) begin
          data_cap_d = i_data;
          cred_cap_d = i_cred;
          state_d    = StCheck;
        end
      end
      StCheck: begin
        st_cnt_d = '0;
        if (cred_cap_q == CRED_KEY) begin
          state_d = StGrant;
          {carry_d, acc_d} = sum;
          if (entries_q != 4'hF) entries_d = entries_q + 4'd1;
          tries_d = 4'd0;
        end else if (tries_q + 4'd1 == TriesMax) begin
          state_d = StLocked;
          tries_d = TriesMax;
        end else begin
          state_d = StDeny;
          tries_d = tries_q + 4'd1;
        end
      end
      StGrant, StDeny, StLocked: begin
        if (tick_q) begin
          if (st_cnt_q == dwell_last) begin
            state_d = StIdle;
            if (state_q == StLocked) tries_d = 4'd0;
          end else begin
            st_cnt_d = st_cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    led_d  = (state_d == StGrant);
    err_d  = (state_d == StDeny);
    lock_d = (state_d == StLocked);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
      st_cnt_q   <= '0;
      acc_q      <= '0;
      carry_q    <= 1'b0;
      entries_q  <= 4'd0;
      tries_q    <= 4'd0;
      data_cap_q <= '0;
      cred_cap_q <= '0;
      led_q      <= 1'b0;
      err_q      <= 1'b0;
      lock_q     <= 1'b0;
      submit_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_d;
      st_cnt_q   <= st_cnt_d;
      acc_q      <= acc_d;
      carry_q    <= carry_d;
      entries_q  <= entries_d;
      tries_q    <= tries_d;
      data_cap_q <= data_cap_d;
      cred_cap_q <= cred_cap_d;
      led_q      <= led_d;
      err_q      <= err_d;
      lock_q     <= lock_d;
      submit_q   <= submit_lvl;
    end
  end

  assign o_acc     = acc_q;
  assign o_carry   = carry_q;
  assign o_entries = entries_q;
  assign o_tries   = tries_q;
  assign o_led     = led_q;
  assign o_err     = err_q;
  assign o_lock    = lock_q;
  assign o_tick    = tick_q;

endmodule

// File: tb/tb_secure_entry_ctrl.sv
// Directed bench for secure_entry_ctrl with a short prescaler (TICK_DIV=4).
module tb_secure_entry_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] i_data, i_cred;
  logic       i_submit;
  logic [3:0] o_acc, o_entries, o_tries;
  logic       o_carry, o_led, o_err, o_lock, o_tick;

  int n_tests = 0;
  int n_fail  = 0;

  secure_entry_ctrl #(
    .DATA_W(4), .CRED_W(4), .CRED_KEY(4'hA), .MAX_TRIES(3),
    .TICK_DIV(4), .GRANT_TICKS(2), .LOCK_TICKS(5), .DEB_CYC(8)
  ) dut (
    .clk(clk), .rst(rst), .i_data(i_data), .i_cred(i_cred), .i_submit(i_submit),
    .o_acc(o_acc), .o_carry(o_carry), .o_entries(o_entries), .o_tries(o_tries),
    .o_led(o_led), .o_err(o_err), .o_lock(o_lock), .o_tick(o_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One-cycle submit pulse; returns at cycle N+2 when results are visible.
  task automatic do_submit(input logic [3:0] d, input logic [3:0] c);
    i_data   = d;
    i_cred   = c;
    i_submit = 1'b1;
    cyc();
    i_submit = 1'b0;
    cyc();
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 40 && (o_led || o_err || o_lock); i++) cyc();
    n_tests++;
    if (o_led || o_err || o_lock) begin
      n_fail++;
      $display("FAIL %s_idle_timeout: led=%0b err=%0b lock=%0b, required all 0",
               name, o_led, o_err, o_lock);
    end
  endtask

  task automatic test_reset();
    logic seen;
    rst = 1'b1; i_submit = 1'b1; i_cred = 4'hA; i_data = 4'h0;
    repeat (3) cyc();
    n_tests++;
    if ({o_acc, o_carry, o_entries, o_tries, o_led, o_err, o_lock, o_tick} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, required 0",
               {o_acc, o_carry, o_entries, o_tries, o_led, o_err, o_lock, o_tick});
    end
    rst = 1'b0;
    cyc();
    n_tests++;
    if (o_tick !== 1'b0) begin n_fail++; $display("FAIL tick_c1: got %0b, required 0", o_tick); end
    cyc();
    n_tests++;
    if (o_tick !== 1'b0 || o_led !== 1'b1 || o_entries !== 4'd1) begin
      n_fail++;
      $display("FAIL held_req_c2: tick=%0b led=%0b entries=%0d, required 0 1 1",
               o_tick, o_led, o_entries);
    end
    cyc();
    n_tests++;
    if (o_tick !== 1'b1) begin n_fail++; $display("FAIL tick_c3: got %0b, required 1", o_tick); end
    wait_idle("reset");
    seen = 1'b0;
    repeat (12) begin cyc(); if (o_led || o_err) seen = 1'b1; end
    n_tests++;
    if (seen !== 1'b0 || o_entries !== 4'd1) begin
      n_fail++;
      $display("FAIL held_single_req: extra_activity=%0b entries=%0d, required 0 1",
               seen, o_entries);
    end
    i_submit = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_tests++;
    if (o_entries !== 4'd0 || o_acc !== 4'd0) begin
      n_fail++;
      $display("FAIL rereset: entries=%0d acc=%h, required 0 0", o_entries, o_acc);
    end
  endtask

  task automatic test_grant();
    int cnt;
    do_submit(4'h5, 4'hA);
    n_tests++;
    if (o_acc !== 4'h5 || o_entries !== 4'd1 || o_led !== 1'b1 || o_tries !== 4'd0 ||
        o_carry !== 1'b0 || o_err !== 1'b0) begin
      n_fail++;
      $display("FAIL grant: acc=%h ent=%0d led=%0b tries=%0d carry=%0b err=%0b, req 5 1 1 0 0 0",
               o_acc, o_entries, o_led, o_tries, o_carry, o_err);
    end
    cnt = 1;
    for (int i = 0; i < 20 && o_led; i++) begin cyc(); if (o_led) cnt++; end
    n_tests++;
    if (!(cnt >= 5 && cnt <= 8)) begin
      n_fail++;
      $display("FAIL grant_dwell: got %0d cycles, required 5..8", cnt);
    end
    wait_idle("grant");
  endtask

  task automatic test_wrap();
    do_submit(4'h9, 4'hA);
    n_tests++;
    if (o_acc !== 4'hE || o_carry !== 1'b0) begin
      n_fail++; $display("FAIL wrap_pre: acc=%h carry=%0b, required E 0", o_acc, o_carry);
    end
    wait_idle("wrap1");
    do_submit(4'h3, 4'hA);
    n_tests++;
    if (o_acc !== 4'h1 || o_carry !== 1'b1 || o_entries !== 4'd3) begin
      n_fail++;
      $display("FAIL wrap_overflow: acc=%h carry=%0b ent=%0d, required 1 1 3",
               o_acc, o_carry, o_entries);
    end
    wait_idle("wrap2");
    do_submit(4'h1, 4'hA);
    n_tests++;
    if (o_acc !== 4'h2 || o_carry !== 1'b0 || o_entries !== 4'd4) begin
      n_fail++;
      $display("FAIL wrap_after: acc=%h carry=%0b ent=%0d, required 2 0 4",
               o_acc, o_carry, o_entries);
    end
    wait_idle("wrap3");
  endtask

  task automatic test_lockout();
    int cnt;
    do_submit(4'h1, 4'h3);
    n_tests++;
    if (o_tries !== 4'd1 || o_err !== 1'b1 || o_lock !== 1'b0) begin
      n_fail++;
      $display("FAIL deny1: tries=%0d err=%0b lock=%0b, required 1 1 0", o_tries, o_err, o_lock);
    end
    wait_idle("deny1");
    do_submit(4'h2, 4'h3);
    n_tests++;
    if (o_tries !== 4'd2 || o_err !== 1'b1) begin
      n_fail++; $display("FAIL deny2: tries=%0d err=%0b, required 2 1", o_tries, o_err);
    end
    wait_idle("deny2");
    do_submit(4'h3, 4'h3);
    n_tests++;
    if (o_lock !== 1'b1 || o_tries !== 4'd3 || o_err !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_enter: lock=%0b tries=%0d err=%0b, required 1 3 0",
               o_lock, o_tries, o_err);
    end
    cnt = 1;
    i_data = 4'hF; i_cred = 4'hA; i_submit = 1'b1;
    cyc();
    if (o_lock) cnt++;
    i_submit = 1'b0;
    repeat (3) begin cyc(); if (o_lock) cnt++; end
    n_tests++;
    if (o_acc !== 4'h2 || o_lock !== 1'b1 || o_entries !== 4'd4 || o_led !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_ignore: acc=%h lock=%0b ent=%0d led=%0b, required 2 1 4 0",
               o_acc, o_lock, o_entries, o_led);
    end
    for (int i = 0; i < 30 && o_lock; i++) begin cyc(); if (o_lock) cnt++; end
    n_tests++;
    if (!(cnt >= 17 && cnt <= 20)) begin
      n_fail++; $display("FAIL lock_dwell: got %0d cycles, required 17..20", cnt);
    end
    n_tests++;
    if (o_tries !== 4'd0 || o_lock !== 1'b0 || o_acc !== 4'h2) begin
      n_fail++;
      $display("FAIL lock_exit: tries=%0d lock=%0b acc=%h, required 0 0 2", o_tries, o_lock, o_acc);
    end
  endtask

  task automatic test_deny_then_grant();
    do_submit(4'h0, 4'h1);
    n_tests++;
    if (o_tries !== 4'd1 || o_err !== 1'b1) begin
      n_fail++; $display("FAIL dg_deny: tries=%0d err=%0b, required 1 1", o_tries, o_err);
    end
    wait_idle("dg1");
    do_submit(4'h4, 4'hA);
    n_tests++;
    if (o_tries !== 4'd0 || o_entries !== 4'd5 || o_acc !== 4'h6 || o_led !== 1'b1) begin
      n_fail++;
      $display("FAIL dg_grant: tries=%0d ent=%0d acc=%h led=%0b, required 0 5 6 1",
               o_tries, o_entries, o_acc, o_led);
    end
    wait_idle("dg2");
  endtask

  task automatic test_rst_locked();
    for (int k = 0; k < 3; k++) begin
      do_submit(4'h0, 4'h5);
      if (k < 2) wait_idle("rl");
    end
    n_tests++;
    if (o_lock !== 1'b1) begin n_fail++; $display("FAIL rl_lock: got %0b, required 1", o_lock); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_tests++;
    if (o_lock !== 1'b0 || o_tries !== 4'd0 || o_acc !== 4'h0 || o_entries !== 4'd0) begin
      n_fail++;
      $display("FAIL rl_reset: lock=%0b tries=%0d acc=%h ent=%0d, required 0 0 0 0",
               o_lock, o_tries, o_acc, o_entries);
    end
    do_submit(4'h7, 4'hA);
    n_tests++;
    if (o_acc !== 4'h7 || o_led !== 1'b1 || o_entries !== 4'd1) begin
      n_fail++;
      $display("FAIL rl_grant: acc=%h led=%0b ent=%0d, required 7 1 1", o_acc, o_led, o_entries);
    end
    wait_idle("rl_end");
  endtask

  task automatic test_debounce();
    logic seen;
    rst = 1'b1; i_submit = 1'b0; i_data = 4'h3; i_cred = 4'hA;
    repeat (2) cyc();
    rst = 1'b0;
    cyc();
    n_tests++;
    if (o_entries !== 4'd0 || o_led !== 1'b0) begin
      n_fail++; $display("FAIL deb_reset: ent=%0d led=%0b, required 0 0", o_entries, o_led);
    end
    seen = 1'b0;
    i_submit = 1'b1;
    repeat (5) begin cyc(); if (o_led) seen = 1'b1; end
    i_submit = 1'b0;
    repeat (25) begin cyc(); if (o_led) seen = 1'b1; end
    n_tests++;
    if (seen !== 1'b0 || o_entries !== 4'd0) begin
      n_fail++; $display("FAIL deb_short: led_seen=%0b ent=%0d, required 0 0", seen, o_entries);
    end
    seen = 1'b0;
    i_submit = 1'b1;
    repeat (12) begin cyc(); if (o_led) seen = 1'b1; end
    i_submit = 1'b0;
    repeat (30) begin cyc(); if (o_led) seen = 1'b1; end
    n_tests++;
    if (seen !== 1'b1 || o_entries !== 4'd1 || o_acc !== 4'h3) begin
      n_fail++;
      $display("FAIL deb_long: led_seen=%0b ent=%0d acc=%h, required 1 1 3", seen, o_entries, o_acc);
    end
  endtask

  initial begin
    rst = 1'b1; i_submit = 1'b0; i_data = 4'h0; i_cred = 4'h0;
`ifdef SUBMIT_DEBOUNCE_EN
    test_debounce();
`else
    test_reset();
    test_grant();
    test_wrap();
    test_lockout();
    test_deny_then_grant();
    test_rst_locked();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
